// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high {g,f,e,d,c,b,a} glyph patterns
// and the nibble-to-glyph decode.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Values 10..15 are dark unless hex glyphs are enabled.
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble, input logic hex_en);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = hex_en ? SEG_A : SEG_OFF;
      4'hB: glyph = hex_en ? SEG_B : SEG_OFF;
      4'hC: glyph = hex_en ? SEG_C : SEG_OFF;
      4'hD: glyph = hex_en ? SEG_D : SEG_OFF;
      4'hE: glyph = hex_en ? SEG_E : SEG_OFF;
      default: glyph = hex_en ? SEG_F : SEG_OFF;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decoder, active-high output.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  localparam logic HEX_ON = (HEX_EN != 0);

  always_comb begin
    seg = nibble_to_seg(nibble, HEX_ON);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scanner with per-frame input snapshot
// and blanking guard cycles around each digit's display window.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SLOT_HZ    = 8_000,
  parameter int N_DIGITS   = 8,
  parameter int BLANK_CYC  = 16,
  parameter int HEX_EN     = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int   DIV = CLK_HZ / SLOT_HZ;
  localparam int   PW  = $clog2(DIV);
  localparam int   IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]               p;
  logic [IW-1:0]               idx;
  logic                        tick;
  logic                        last;
  logic [N_DIGITS-1:0][3:0]    snap_digits;
  logic [N_DIGITS-1:0]         snap_dp;
  logic [N_DIGITS-1:0]         snap_blank;
  logic [3:0]                  cur_nib;
  logic [6:0]                  dec_seg;
  logic                        win;
  logic                        upd;
  logic [N_DIGITS-1:0]         an_hot;

  assign tick       = (p == PW'(DIV - 1));
  assign last       = (idx == IW'(N_DIGITS - 1));
  assign frame_done = tick && last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p   <= '0;
      idx <= '0;
    end else begin
      p <= tick ? '0 : p + 1'b1;
      if (tick) idx <= last ? '0 : idx + 1'b1;
    end
  end

  // Inputs are captured only at the frame boundary so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '1;
    end else if (frame_done) begin
      snap_digits <= digits_in;
      snap_dp     <= dp_in;
      snap_blank  <= blank_in;
    end
  end

  assign cur_nib = snap_digits[idx];

  seg7_decoder #(
    .HEX_EN(HEX_EN)
  ) u_decoder (
    .nibble(cur_nib),
    .seg   (dec_seg)
  );

  // Window excludes p == DIV-1 so adjacent slots never overlap at the pins.
  always_comb begin
    win    = !snap_blank[idx] && (int'(p) >= BLANK_CYC) && (int'(p) <= DIV - 2);
    upd    = (int'(p) < BLANK_CYC);
    an_hot = '0;
    if (win) an_hot[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= {N_DIGITS{POL}};
      seg <= {7{POL}};
      dp  <= POL;
    end else begin
      an <= an_hot ^ {N_DIGITS{POL}};
      if (upd) begin
        seg <= (snap_blank[idx] ? SEG_OFF : dec_seg) ^ {7{POL}};
        dp  <= (snap_dp[idx] && !snap_blank[idx]) ^ POL;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIV=10, 8 digits, 2 guard cycles).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fd0, fd1;

  int checks = 0;
  int errors = 0;
  int e;
  logic [31:0] snap_d;
  logic [7:0]  snap_dp, snap_bl;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_HZ(100), .SLOT_HZ(10), .N_DIGITS(8), .BLANK_CYC(2), .HEX_EN(0), .ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
  );

  seg7_scan_driver #(
    .CLK_HZ(100), .SLOT_HZ(10), .N_DIGITS(8), .BLANK_CYC(2), .HEX_EN(1), .ACTIVE_LOW(1)
  ) u_dut_hex (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n, input bit hex);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;
      4'hA: return hex ? 7'h77 : 7'h00;
      4'hB: return hex ? 7'h7C : 7'h00;
      4'hC: return hex ? 7'h39 : 7'h00;
      4'hD: return hex ? 7'h5E : 7'h00;
      4'hE: return hex ? 7'h79 : 7'h00;
      default: return hex ? 7'h71 : 7'h00;
    endcase
  endfunction

  task automatic reset_model();
    e       = 0;
    snap_d  = '0;
    snap_dp = '0;
    snap_bl = 8'hFF;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an0"},  an0,  32'hFF);
    check({tag, "_an1"},  an1,  32'hFF);
    check({tag, "_seg0"}, seg0, 32'h7F);
    check({tag, "_seg1"}, seg1, 32'h7F);
    check({tag, "_dp0"},  dp0,  32'h1);
    check({tag, "_fd0"},  fd0,  32'h0);
  endtask

  // Advance one clock; outputs after edge e reflect scan state e-1.
  task automatic step_check();
    logic [31:0] od;
    logic [7:0]  odp, obl, exp_an;
    logic [3:0]  nib;
    logic [6:0]  exp_s0, exp_s1;
    logic        act, exp_dp;
    int s, p, slot;
    string t;
    @(posedge clk);
    e++;
    od  = snap_d;
    odp = snap_dp;
    obl = snap_bl;
    if (e % 80 == 0) begin
      snap_d  = digits_in;
      snap_dp = dp_in;
      snap_bl = blank_in;
    end
    #1;
    s    = e - 1;
    p    = s % 10;
    slot = (s / 10) % 8;
    nib  = od[slot*4 +: 4];
    act  = !obl[slot] && p >= 2 && p <= 8;
    exp_an = act ? ~(8'b1 << slot) : 8'hFF;
    exp_s0 = obl[slot] ? 7'h7F : ~glyph(nib, 1'b0);
    exp_s1 = obl[slot] ? 7'h7F : ~glyph(nib, 1'b1);
    exp_dp = obl[slot] ? 1'b1 : ~odp[slot];
    t = $sformatf("e%0d", e);
    check({t, "_an"},     an0,  exp_an);
    check({t, "_an_hex"}, an1,  exp_an);
    check({t, "_seg"},    seg0, exp_s0);
    check({t, "_seg_hex"},seg1, exp_s1);
    check({t, "_dp"},     dp0,  exp_dp);
    check({t, "_dp_hex"}, dp1,  exp_dp);
    check({t, "_fd"},     fd0,  32'(e % 80 == 79));
    check({t, "_fd_hex"}, fd1,  32'(e % 80 == 79));
    check({t, "_onehot"}, 32'($countones(~an0) <= 1), 32'h1);
  endtask

  initial begin
    reset     = 1'b1;
    digits_in = 32'h7654_3210;
    dp_in     = 8'h00;
    blank_in  = 8'h00;
    reset_model();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Frames 0-1: counting digits; frame 2 digits 1s, change to 2s mid-frame;
    // frame 4 nibble C on digit 2; frame 5 blank/dp pattern.
    while (e < 465) begin
      step_check();
      case (e)
        100: digits_in = 32'h1111_1111;
        205: digits_in = 32'h2222_2222;
        260: digits_in = 32'h0000_0C00;
        340: begin
          digits_in = 32'h9876_5432;
          blank_in  = 8'h0F;
          dp_in     = 8'h20;
        end
        default: ;
      endcase
    end

    // State is now slot 6, p=5 with digit 6 lit; reset must blank outputs immediately.
    check("pre_rst_an", an0, 32'hBF);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    digits_in = 32'h7654_3210;
    blank_in  = 8'h00;
    dp_in     = 8'h00;
    reset_model();
    @(negedge clk);
    reset = 1'b0;
    while (e < 175) step_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", e, 175);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Consumes the BCD digit outputs of the RISC_V top: data-memory and register-file tens/units nibbles, plus flag bits routed to decimal points. Drives a time-multiplexed common-anode 8-digit seven-segment display on the FPGA board. Snapshots all inputs once per scan frame so a digit pattern never tears mid-frame. Adds a guard interval between digits to suppress ghosting.

Parameters:
CLK_HZ, 100_000_000, input clock frequency
SLOT_HZ, 8_000, digit-slot rate; DIV = CLK_HZ/SLOT_HZ cycles per slot; DIV must be >= 4
N_DIGITS, 8, number of digits scanned
BLANK_CYC, 16, guard cycles at the start of each slot with all anodes off; must be < DIV-1
HEX_EN, 0, 1 = nibble values 10..15 show A,b,C,d,E,F; 0 = values 10..15 show blank
ACTIVE_LOW, 1, 1 = an/seg/dp pins are active-low

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
digits_in  in  4*N_DIGITS  digit i at [4i+3:4i]; digit 0 is rightmost
dp_in  in  N_DIGITS  decimal point per digit (e.g. RISC_RF19/RISC_RF21)
blank_in  in  N_DIGITS  1 = digit i dark regardless of value
an  out  N_DIGITS  anode enables, one-hot active during the display window
seg  out  7  {g,f,e,d,c,b,a}
dp  out  1  decimal point of the current digit
frame_done  out  1  single-cycle pulse marking the snapshot/frame boundary

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-high. All state is cleared immediately on reset assertion.
- Reset values, with inactive meaning the ACTIVE_LOW-correct level:
  - an all inactive; seg all off; dp off; frame_done 0.
  - Prescaler p = 0; digit index idx = 0.
  - Snapshot digits = 0; snapshot dp = 0; snapshot blank = all 1s, so the first frame is dark.
- Prescaler p counts 0..DIV-1 and wraps to 0. tick = (p == DIV-1).
- On tick, idx advances: idx+1, with N_DIGITS-1 wrapping to 0.
- Snapshot: on tick with idx == N_DIGITS-1, register digits_in, dp_in and blank_in, and pulse frame_done for exactly that cycle. Inputs are ignored at all other times, so mid-frame input changes appear only from the next frame.
- Output stage, registered one cycle after (idx, p):
  - an[idx] active iff BLANK_CYC <= p <= DIV-2. p == DIV-1 is a trailing guard cycle, so no two anodes are ever active together.
  - seg = decode(snapshot nibble idx) and dp = snapshot dp[idx], updated while anodes are off (p < BLANK_CYC).
  - If snapshot blank[idx] = 1: seg off, dp off, an stays inactive for the whole slot.
- Decode, active-high before polarity inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - HEX_EN=1: A=77, b=7C, C=39, d=5E, E=79, F=71. HEX_EN=0: 10..15 = 00.
- ACTIVE_LOW=1 inverts an, seg and dp at the output registers.
- Frame period = N_DIGITS*DIV cycles; the first frame_done occurs N_DIGITS*DIV-1 cycles after reset release.
- Reset mid-slot: outputs go inactive asynchronously. The scan restarts at idx 0, p 0, and the display stays dark for one full frame.

Decomposition:
- Package seg7_pkg: segment pattern localparams (SEG_0..SEG_F, SEG_OFF) and function nibble_to_seg(nibble, hex_en) returning the 7-bit active-high pattern.
- Sub-module seg7_decoder: combinational nibble-to-segment decode using the package function. It is reused by any future static-digit displays.
- seg7_scan_driver holds the prescaler, index counter, snapshot registers and output registers.

Test Plan:
All tests use CLK_HZ=100, SLOT_HZ=10 (DIV=10), N_DIGITS=8, BLANK_CYC=2, ACTIVE_LOW=1.
1. Reset release, digits_in=0x76543210, blank_in=0:
   - Frame 1: an=FF throughout.
   - frame_done at cycle 79.
   - Frame 2, slot 0: an=FE for exactly 7 cycles, seg=~3F.
   - Slot 3: an=F7, seg=~4F.
2. digits_in changed from 0x11111111 to 0x22222222 during slot 4 of a frame -> digits 4..7 of that frame still show ~06; the next frame shows ~5B on all digits.
3. Nibble 0xC on digit 2:
   - HEX_EN=0 -> seg=~00 during slot 2.
   - HEX_EN=1 -> seg=~39.
4. blank_in=0x0F, dp_in=0x20:
   - Digits 0..3 never drive an low.
   - Digit 5 shows dp=0 (lit); all other digits show dp=1.
5. Reset asserted at p=5 of slot 6:
   - an=FF and seg=7F in the same cycle, without waiting for a clock edge.
   - After release, a dark frame, then the scan restarts at digit 0.
6. Overlap check across 3 frames, sampling every cycle:
   - an is never non-one-hot (at most one bit 0).
   - an=FF during p=0..1 and p=9 of every slot.
